// File: rtl/lsu_data_memory_pkg.sv
// Shared memory-access encodings, response record and byte-lane helpers.
// Pure definitions; no logic of its own.
// Imported by lsu_data_memory and mem_load_align.
package lsu_data_memory_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int BYTE_LANES         = 4;

    localparam logic [1:0] BYTE_MEMORY_MODE     = 2'b00;
    localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'b01;
    localparam logic [1:0] WORD_MEMORY_MODE     = 2'b10;
    localparam logic [1:0] MEM_UNIT_ILLEGAL     = 2'b11;

    typedef enum logic {
        MEM_ST_INIT = 1'b0,
        MEM_ST_RUN  = 1'b1
    } mem_state_t;

    // One stage of the response pipeline.
    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] dat;
    } mem_rsp_t;

    // Lanes touched by an access of the given unit at the given byte offset.
    function automatic logic [BYTE_LANES-1:0] byte_enable(input logic [1:0] unit,
                                                          input logic [1:0] offset);
        logic [BYTE_LANES-1:0] be;
        case (unit)
            BYTE_MEMORY_MODE:     be = 4'b0001 << offset;
            HALFWORD_MEMORY_MODE: be = offset[1] ? 4'b1100 : 4'b0011;
            WORD_MEMORY_MODE:     be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Misaligned halfword/word, or an illegal unit encoding.
    function automatic logic access_error(input logic [1:0] unit, input logic [1:0] offset);
        return ((unit == HALFWORD_MEMORY_MODE) && offset[0])
            || ((unit == WORD_MEMORY_MODE) && (offset != 2'b00))
            || (unit == MEM_UNIT_ILLEGAL);
    endfunction

    // Replicate the low-order store bytes onto every lane so the byte enables pick them up.
    function automatic logic [31:0] store_lanes(input logic [1:0] unit, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (unit)
            BYTE_MEMORY_MODE:     lanes = {4{wdata[7:0]}};
            HALFWORD_MEMORY_MODE: lanes = {2{wdata[15:0]}};
            default:              lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it to 32 bits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mem_load_align
    import lsu_data_memory_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  unit_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane selection followed by sign or zero extension.
    always_comb begin
        byte_sel = word_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (unit_i)
            BYTE_MEMORY_MODE:     data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            HALFWORD_MEMORY_MODE: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            WORD_MEMORY_MODE:     data_o = word_i;
            default:              data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressed 32-bit-word data memory with valid/ready requests and aligned loads/stores.
// Latency: LATENCY cycles from acceptance to a one-cycle response; optional zeroing sweep after reset.
// Backpressure: req_ready_o low until initialisation completes; responses cannot be stalled.
module lsu_data_memory
    import lsu_data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_unit_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WORD_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [WORD_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;

    if (WORD_WIDTH != 32) begin : g_bad_word_width
        $error("lsu_data_memory: WORD_WIDTH must be 32");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("lsu_data_memory: LATENCY must be 1..4");
    end

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    mem_state_t       state_q;
    logic             req_ready_q;
    logic [IDX_W:0]   clr_idx_q;     // extra MSB marks the sweep as finished
    mem_rsp_t         pipe_q [LATENCY];
    mem_rsp_t         rsp_d;

    logic             accept;
    logic             req_err;
    logic             wr_en;
    logic             clr_en;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    logic [3:0]       be;
    logic [31:0]      wr_lanes;
    logic [31:0]      load_val;

    assign accept   = req_valid_i & req_ready_q;
    assign word_idx = req_addr_i[ADDR_WIDTH-1:2];
    assign offset   = req_addr_i[1:0];
    assign req_err  = access_error(req_unit_i, offset);
    assign be       = byte_enable(req_unit_i, offset);
    assign wr_lanes = store_lanes(req_unit_i, req_wdata_i);
    assign wr_en    = accept & req_write_i & ~req_err;
    assign clr_en   = (state_q == MEM_ST_INIT) & CLEAR_ON_RESET & ~clr_idx_q[IDX_W];

    mem_load_align u_load_align (
        .word_i     (mem_q[word_idx]),
        .offset_i   (offset),
        .unit_i     (req_unit_i),
        .unsigned_i (req_unsigned_i),
        .data_o     (load_val)
    );

    // INIT -> RUN sequencing, sweep index and the registered ready flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= MEM_ST_INIT;
            req_ready_q <= 1'b0;
            clr_idx_q   <= '0;
        end else begin
            case (state_q)
                MEM_ST_INIT: begin
                    if (clr_en) begin
                        clr_idx_q <= clr_idx_q + {{IDX_W{1'b0}}, 1'b1};
                    end else begin
                        state_q     <= MEM_ST_RUN;
                        req_ready_q <= 1'b1;
                    end
                end
                MEM_ST_RUN: req_ready_q <= 1'b1;
                default: begin
                    state_q     <= MEM_ST_INIT;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: zeroing sweep during INIT, byte-lane stores in RUN. Contents survive reset.
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            mem_q[clr_idx_q[IDX_W-1:0]] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTE_LANES; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // First response stage: data only for good loads, so rdata stays zero otherwise.
    always_comb begin
        rsp_d     = '0;
        rsp_d.vld = accept;
        rsp_d.err = accept & req_err;
        if (accept && !req_write_i && !req_err) begin
            rsp_d.dat = load_val;
        end
    end

    // Response shift pipeline; reset flushes anything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q[0] <= rsp_d;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = pipe_q[LATENCY-1].vld;
    assign rsp_err_o   = pipe_q[LATENCY-1].err;
    assign rsp_rdata_o = pipe_q[LATENCY-1].dat;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench: three instances (LATENCY=1, LATENCY=3, CLEAR_ON_RESET=1 with ADDR_WIDTH=6).
// Vector table on the LATENCY=1 memory, hand sequences for pipelining, reset flush and clear sweep.
// Inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_lsu_data_memory;
    import lsu_data_memory_pkg::*;

    logic        clk;
    logic        rst          [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_write    [3];
    logic [1:0]  req_unit     [3];
    logic        req_unsigned [3];
    logic [7:0]  req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    lsu_data_memory #(.ADDR_WIDTH(8), .WORD_WIDTH(32), .LATENCY(1), .CLEAR_ON_RESET(1'b0)) u_l1 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_write_i(req_write[0]), .req_unit_i(req_unit[0]), .req_unsigned_i(req_unsigned[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

    lsu_data_memory #(.ADDR_WIDTH(8), .WORD_WIDTH(32), .LATENCY(3), .CLEAR_ON_RESET(1'b0)) u_l3 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_write_i(req_write[1]), .req_unit_i(req_unit[1]), .req_unsigned_i(req_unsigned[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

    lsu_data_memory #(.ADDR_WIDTH(6), .WORD_WIDTH(32), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_clr (
        .clk_i(clk), .rst_i(rst[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_write_i(req_write[2]), .req_unit_i(req_unit[2]), .req_unsigned_i(req_unsigned[2]),
        .req_addr_i(req_addr[2][5:0]), .req_wdata_i(req_wdata[2]), .rsp_valid_o(rsp_valid[2]),
        .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

    typedef struct {
        bit          wr;
        logic [1:0]  unit;
        bit          uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_dat;
        bit          exp_err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input bit wr, input logic [1:0] unit, input bit uns,
                         input logic [7:0] addr, input logic [31:0] wd);
        req_valid[k]    = 1'b1;
        req_write[k]    = wr;
        req_unit[k]     = unit;
        req_unsigned[k] = uns;
        req_addr[k]     = addr;
        req_wdata[k]    = wd;
    endtask

    // Counts rising edges after a falling-edge reset release until ready is seen high.
    task automatic wait_ready(input int k, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready[k] && n < 100);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] exp_d;
        logic        exp_v;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_unit[k] = 2'b00;
            req_unsigned[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
        end

        vecs[0]  = '{1'b1, WORD_MEMORY_MODE,     1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, BYTE_MEMORY_MODE,     1'b0, 8'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[2]  = '{1'b0, BYTE_MEMORY_MODE,     1'b1, 8'h13, 32'h0,        32'h000000DE, 1'b0};
        vecs[3]  = '{1'b0, HALFWORD_MEMORY_MODE, 1'b1, 8'h10, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[4]  = '{1'b0, HALFWORD_MEMORY_MODE, 1'b0, 8'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b0, HALFWORD_MEMORY_MODE, 1'b0, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[6]  = '{1'b0, BYTE_MEMORY_MODE,     1'b0, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[7]  = '{1'b1, BYTE_MEMORY_MODE,     1'b0, 8'h11, 32'hAABBCC55, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, WORD_MEMORY_MODE,     1'b0, 8'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[9]  = '{1'b0, WORD_MEMORY_MODE,     1'b0, 8'h12, 32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b1, WORD_MEMORY_MODE,     1'b0, 8'h20, 32'h11223344, 32'h00000000, 1'b0};
        vecs[11] = '{1'b1, HALFWORD_MEMORY_MODE, 1'b0, 8'h21, 32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, WORD_MEMORY_MODE,     1'b0, 8'h20, 32'h0,        32'h11223344, 1'b0};
        vecs[13] = '{1'b0, MEM_UNIT_ILLEGAL,     1'b0, 8'h20, 32'h0,        32'h00000000, 1'b1};
        vecs[14] = '{1'b1, HALFWORD_MEMORY_MODE, 1'b0, 8'h22, 32'hA5A5CAFE, 32'h00000000, 1'b0};
        vecs[15] = '{1'b0, WORD_MEMORY_MODE,     1'b0, 8'h20, 32'h0,        32'hCAFE3344, 1'b0};
        vecs[16] = '{1'b0, WORD_MEMORY_MODE,     1'b1, 8'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[17] = '{1'b0, BYTE_MEMORY_MODE,     1'b0, 8'h21, 32'h0,        32'h00000033, 1'b0};
        vecs[18] = '{1'b1, MEM_UNIT_ILLEGAL,     1'b0, 8'h20, 32'h0,        32'h00000000, 1'b1};
        vecs[19] = '{1'b0, WORD_MEMORY_MODE,     1'b0, 8'h20, 32'h0,        32'hCAFE3344, 1'b0};

        // Reset state of every instance
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ready%0d", k), {31'b0, req_ready[k]}, 32'h0);
            check($sformatf("rst_valid%0d", k), {31'b0, rsp_valid[k]}, 32'h0);
            check($sformatf("rst_rdata%0d", k), rsp_rdata[k], 32'h0);
            check($sformatf("rst_err%0d", k),   {31'b0, rsp_err[k]},   32'h0);
        end

        // Release the two plain memories; INIT lasts a single cycle
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        wait_ready(0, n);
        check("l1_ready_delay", n, 32'd1);
        check("l3_ready_after_init", {31'b0, req_ready[1]}, 32'h1);

        // Table of single requests on the LATENCY=1 memory
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(0, vecs[i].wr, vecs[i].unit, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            check($sformatf("v%0d_valid", i), {31'b0, rsp_valid[0]}, 32'h1);
            check($sformatf("v%0d_err", i),   {31'b0, rsp_err[0]},   {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), rsp_rdata[0], vecs[i].exp_dat);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_one_cycle", i), {rsp_valid[0], rsp_rdata[0][30:0]}, 32'h0);
        end

        // LATENCY=3: four back-to-back stores, then four back-to-back loads
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            if (e < 4) drive(1, 1'b1, WORD_MEMORY_MODE, 1'b0, 8'(4*e), 32'h100 + e);
            else       req_valid[1] = 1'b0;
            @(posedge clk);
            #1;
            exp_v = (e >= 2 && e <= 5);
            check($sformatf("l3_st_valid_e%0d", e), {31'b0, rsp_valid[1]}, {31'b0, exp_v});
        end
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            if (e < 4) drive(1, 1'b0, WORD_MEMORY_MODE, 1'b0, 8'(4*e), 32'h0);
            else       req_valid[1] = 1'b0;
            @(posedge clk);
            #1;
            exp_v = (e >= 2 && e <= 5);
            exp_d = exp_v ? 32'h100 + 32'(e - 2) : 32'h0;
            check($sformatf("l3_ld_valid_e%0d", e), {31'b0, rsp_valid[1]}, {31'b0, exp_v});
            check($sformatf("l3_ld_rdata_e%0d", e), rsp_rdata[1], exp_d);
        end

        // LATENCY=3: reset with two loads in flight flushes them
        @(negedge clk);
        drive(1, 1'b0, WORD_MEMORY_MODE, 1'b0, 8'h00, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, WORD_MEMORY_MODE, 1'b0, 8'h04, 32'h0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("l3_inflight_not_out", {31'b0, rsp_valid[1]}, 32'h0);
        #1;
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1] !== 1'b0) n++;
        end
        check("l3_flush_no_rsp", n, 32'd0);
        check("l3_ready_after_rst", {31'b0, req_ready[1]}, 32'h1);

        // Clearing memory: first sweep after power-up reset
        @(negedge clk);
        rst[2] = 1'b0;
        wait_ready(2, n);
        check("clr_ready_delay_first", n, 32'd17);

        // Fill with non-zero words so the next sweep has something to erase
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(2, 1'b1, WORD_MEMORY_MODE, 1'b0, 8'(4*i), 32'hA5000000 | i);
            @(posedge clk);
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("clr_ready_mid_sweep", {31'b0, req_ready[2]}, 32'h0);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        wait_ready(2, n);
        check("clr_ready_delay_restart", n, 32'd17);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(2, 1'b0, WORD_MEMORY_MODE, 1'b0, 8'(4*i), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("clr_word%0d_valid", i), {31'b0, rsp_valid[2]}, 32'h1);
            check($sformatf("clr_word%0d_rdata", i), rsp_rdata[2], 32'h0);
        end
        @(negedge clk);
        req_valid[2] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
